// File: rtl/sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : sram_arbiter
// Purpose  : Arbitrates NUM_PORTS CPU memory requesters onto the BaseRAM and
//            ExtRAM board SRAMs. Supports fixed or round-robin priority,
//            programmable access wait states, byte-enable writes, and an
//            error response for addresses outside the SRAM window.
// Ports    : clk, reset                     - clock, sync active-high reset
//            req_valid/req_ready            - per-port request handshake
//            req_be/req_addr/req_wdata      - per-port request payload
//            resp_valid/resp_rdata          - completion pulse, shared data
//            base_ram_* / ext_ram_*         - SRAM pins (active-low controls)
// Revision : 1.0 - initial release
// ============================================================================
module sram_arbiter #(
    parameter int NUM_PORTS   = 2,
    parameter int ARB_MODE    = 0,
    parameter int WAIT_CYCLES = 1,
    parameter int SRAM_AW     = 20,
    parameter int BANK_BIT    = 22
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NUM_PORTS-1:0]    req_valid,
    output logic [NUM_PORTS-1:0]    req_ready,
    input  logic [NUM_PORTS*4-1:0]  req_be,
    input  logic [NUM_PORTS*32-1:0] req_addr,
    input  logic [NUM_PORTS*32-1:0] req_wdata,
    output logic [NUM_PORTS-1:0]    resp_valid,
    output logic [31:0]             resp_rdata,
    inout  wire  [31:0]             base_ram_data,
    output logic [SRAM_AW-1:0]      base_ram_addr,
    output logic [3:0]              base_ram_be_n,
    output logic                    base_ram_ce_n,
    output logic                    base_ram_oe_n,
    output logic                    base_ram_we_n,
    inout  wire  [31:0]             ext_ram_data,
    output logic [SRAM_AW-1:0]      ext_ram_addr,
    output logic [3:0]              ext_ram_be_n,
    output logic                    ext_ram_ce_n,
    output logic                    ext_ram_oe_n,
    output logic                    ext_ram_we_n
);

    localparam int c_PORT_W = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1;
    typedef logic [c_PORT_W-1:0] port_t;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_ACCESS  = 2'd1,
        S_RECOVER = 2'd2,
        S_ERR     = 2'd3
    } state_t;

    state_t              r_state;
    logic [2:0]          r_cnt;
    port_t               r_port;
    port_t               r_rr_ptr;
    logic                r_bank;
    logic                r_write;
    logic [SRAM_AW-1:0]  r_word;
    logic [3:0]          r_be;
    logic [31:0]         r_wdata;
    logic [31:0]         r_rdata;

    logic                w_any;
    port_t               w_win;
    int                  w_dist;
    int                  w_best;
    logic [31:0]         w_sel_addr;
    logic [3:0]          w_sel_be;
    logic [31:0]         w_sel_wdata;
    logic                w_mapped;
    logic                w_access;
    logic                w_active;
    logic                w_unused_addr;

    // Winner = set request with the smallest distance. Fixed mode uses the
    // index itself; round-robin measures distance past the pointer, so the
    // pointer's own port ranks last.
    always_comb begin
        w_any  = |req_valid;
        w_win  = '0;
        w_best = NUM_PORTS + 1;
        w_dist = 0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (ARB_MODE == 0)
                w_dist = j;
            else if (j > int'(r_rr_ptr))
                w_dist = j - int'(r_rr_ptr);
            else
                w_dist = j - int'(r_rr_ptr) + NUM_PORTS;
            if (req_valid[j] && (w_dist < w_best)) begin
                w_best = w_dist;
                w_win  = port_t'(j);
            end
        end
    end

    always_comb begin
        w_sel_addr  = '0;
        w_sel_be    = '0;
        w_sel_wdata = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            if (port_t'(j) == w_win) begin
                w_sel_addr  = req_addr[j*32 +: 32];
                w_sel_be    = req_be[j*4 +: 4];
                w_sel_wdata = req_wdata[j*32 +: 32];
            end
        end
    end

    assign w_mapped      = (w_sel_addr[31:23] == 9'h100);
    assign w_unused_addr = ^w_sel_addr;

    always_comb begin
        req_ready  = '0;
        resp_valid = '0;
        for (int j = 0; j < NUM_PORTS; j++) begin
            req_ready[j]  = (r_state == S_IDLE) && w_any && !reset && (port_t'(j) == w_win);
            resp_valid[j] = ((r_state == S_RECOVER) || (r_state == S_ERR)) && (port_t'(j) == r_port);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state  <= S_IDLE;
            r_cnt    <= 3'd0;
            r_port   <= '0;
            r_rr_ptr <= port_t'(NUM_PORTS - 1);
            r_bank   <= 1'b0;
            r_write  <= 1'b0;
            r_word   <= '0;
            r_be     <= 4'd0;
            r_wdata  <= 32'd0;
            r_rdata  <= 32'd0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_any) begin
                        r_port   <= w_win;
                        r_rr_ptr <= w_win;
                        r_word   <= w_sel_addr[SRAM_AW+1:2];
                        r_bank   <= w_sel_addr[BANK_BIT];
                        r_be     <= w_sel_be;
                        r_write  <= |w_sel_be;
                        r_wdata  <= w_sel_wdata;
                        // Cleared here so writes and errors report zero data.
                        r_rdata  <= 32'd0;
                        r_cnt    <= 3'd0;
                        r_state  <= w_mapped ? S_ACCESS : S_ERR;
                    end
                end
                S_ACCESS: begin
                    if (r_cnt == 3'(WAIT_CYCLES)) begin
                        if (!r_write)
                            r_rdata <= r_bank ? ext_ram_data : base_ram_data;
                        r_state <= S_RECOVER;
                    end else begin
                        r_cnt <= r_cnt + 3'd1;
                    end
                end
                S_RECOVER: r_state <= S_IDLE;
                S_ERR:     r_state <= S_IDLE;
                default:   r_state <= S_IDLE;
            endcase
        end
    end

    assign resp_rdata = r_rdata;

    // Address and write data stay valid through RECOVER for SRAM hold time;
    // the strobes only cover ACCESS.
    assign w_access = (r_state == S_ACCESS);
    assign w_active = (r_state == S_ACCESS) || (r_state == S_RECOVER);

    assign base_ram_addr = (w_active && !r_bank) ? r_word : '0;
    assign base_ram_ce_n = !(w_access && !r_bank);
    assign base_ram_oe_n = !(w_access && !r_bank && !r_write);
    assign base_ram_we_n = !(w_access && !r_bank && r_write);
    assign base_ram_be_n = (w_access && !r_bank) ? (r_write ? ~r_be : 4'b0000) : 4'b1111;
    assign base_ram_data = (w_active && !r_bank && r_write) ? r_wdata : 'z;

    assign ext_ram_addr  = (w_active && r_bank) ? r_word : '0;
    assign ext_ram_ce_n  = !(w_access && r_bank);
    assign ext_ram_oe_n  = !(w_access && r_bank && !r_write);
    assign ext_ram_we_n  = !(w_access && r_bank && r_write);
    assign ext_ram_be_n  = (w_access && r_bank) ? (r_write ? ~r_be : 4'b0000) : 4'b1111;
    assign ext_ram_data  = (w_active && r_bank && r_write) ? r_wdata : 'z;

endmodule
`default_nettype wire

// File: tb/tb_sram_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_sram_arbiter
// Purpose  : Directed self-checking bench for sram_arbiter. dut_f uses fixed
//            priority with one wait state, dut_r uses round-robin with three.
//            Simple SRAM models return a fixed word per bank on reads.
// Revision : 1.0 - initial release
// ============================================================================
module tb_sram_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  valid_f, valid_r;
    logic [7:0]  be;
    logic [63:0] addr, wdata;
    int          total = 0;
    int          bad   = 0;

    wire  [1:0]  ready_f, ready_r, rv_f, rv_r;
    wire  [31:0] rd_f, rd_r;
    wire  [31:0] bd_f, ed_f, bd_r, ed_r;
    wire  [19:0] ba_f, ea_f, ba_r, ea_r;
    wire  [3:0]  bbe_f, ebe_f, bbe_r, ebe_r;
    wire         bce_f, boe_f, bwe_f, ece_f, eoe_f, ewe_f;
    wire         bce_r, boe_r, bwe_r, ece_r, eoe_r, ewe_r;

    localparam logic [31:0] c_BASE_WORD = 32'h1234_5678;
    localparam logic [31:0] c_EXT_WORD  = 32'h9ABC_DEF0;

    always #5 clk = ~clk;

    assign bd_f = (!bce_f && !boe_f) ? c_BASE_WORD : 'z;
    assign ed_f = (!ece_f && !eoe_f) ? c_EXT_WORD  : 'z;
    assign bd_r = (!bce_r && !boe_r) ? c_BASE_WORD : 'z;
    assign ed_r = (!ece_r && !eoe_r) ? c_EXT_WORD  : 'z;

    sram_arbiter #(.NUM_PORTS(2), .ARB_MODE(0), .WAIT_CYCLES(1)) dut_f (
        .clk(clk), .reset(reset), .req_valid(valid_f), .req_ready(ready_f),
        .req_be(be), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv_f), .resp_rdata(rd_f),
        .base_ram_data(bd_f), .base_ram_addr(ba_f), .base_ram_be_n(bbe_f),
        .base_ram_ce_n(bce_f), .base_ram_oe_n(boe_f), .base_ram_we_n(bwe_f),
        .ext_ram_data(ed_f), .ext_ram_addr(ea_f), .ext_ram_be_n(ebe_f),
        .ext_ram_ce_n(ece_f), .ext_ram_oe_n(eoe_f), .ext_ram_we_n(ewe_f)
    );

    sram_arbiter #(.NUM_PORTS(2), .ARB_MODE(1), .WAIT_CYCLES(3)) dut_r (
        .clk(clk), .reset(reset), .req_valid(valid_r), .req_ready(ready_r),
        .req_be(be), .req_addr(addr), .req_wdata(wdata),
        .resp_valid(rv_r), .resp_rdata(rd_r),
        .base_ram_data(bd_r), .base_ram_addr(ba_r), .base_ram_be_n(bbe_r),
        .base_ram_ce_n(bce_r), .base_ram_oe_n(boe_r), .base_ram_we_n(bwe_r),
        .ext_ram_data(ed_r), .ext_ram_addr(ea_r), .ext_ram_be_n(ebe_r),
        .ext_ram_ce_n(ece_r), .ext_ram_oe_n(eoe_r), .ext_ram_we_n(ewe_r)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset;
        reset = 1'b1; valid_f = 2'b00; valid_r = 2'b00;
        be = '0; addr = '0; wdata = '0;
        tick; tick; tick;
        total++; if (ready_f !== 2'b00 || ready_r !== 2'b00) begin bad++; $display("FAIL reset_ready got=%b/%b exp=00/00", ready_f, ready_r); end
        total++; if (rv_f !== 2'b00 || rv_r !== 2'b00) begin bad++; $display("FAIL reset_resp_valid got=%b/%b exp=00/00", rv_f, rv_r); end
        total++; if (rd_f !== 32'd0 || rd_r !== 32'd0) begin bad++; $display("FAIL reset_rdata got=%h/%h exp=0", rd_f, rd_r); end
        total++; if ({bce_f, boe_f, bwe_f, ece_f, eoe_f, ewe_f} !== 6'b111111) begin bad++; $display("FAIL reset_ctrl got=%b exp=111111", {bce_f, boe_f, bwe_f, ece_f, eoe_f, ewe_f}); end
        total++; if (bbe_f !== 4'hF || ebe_f !== 4'hF || ba_f !== 20'd0 || ea_f !== 20'd0) begin bad++; $display("FAIL reset_be_addr got=%b %b %h %h exp=1111 1111 0 0", bbe_f, ebe_f, ba_f, ea_f); end
        reset = 1'b0;
        tick;
    endtask

    task automatic test_read_base;
        valid_f = 2'b10; addr = {32'h8000_0010, 32'h0}; be = 8'h00; wdata = '0;
        #1;
        total++; if (ready_f !== 2'b10) begin bad++; $display("FAIL t1_ready got=%b exp=10", ready_f); end
        tick; valid_f = 2'b00;
        for (int k = 0; k < 2; k++) begin
            total++; if (ba_f !== 20'h00004) begin bad++; $display("FAIL t1_addr cyc%0d got=%h exp=00004", k, ba_f); end
            total++; if ({bce_f, boe_f, bwe_f, ece_f} !== 4'b0011) begin bad++; $display("FAIL t1_ctrl cyc%0d got=%b exp=0011", k, {bce_f, boe_f, bwe_f, ece_f}); end
            total++; if (rv_f !== 2'b00) begin bad++; $display("FAIL t1_early_resp cyc%0d got=%b exp=00", k, rv_f); end
            tick;
        end
        total++; if (rv_f !== 2'b10) begin bad++; $display("FAIL t1_resp_valid got=%b exp=10", rv_f); end
        total++; if (rd_f !== 32'h1234_5678) begin bad++; $display("FAIL t1_rdata got=%h exp=12345678", rd_f); end
        total++; if (bce_f !== 1'b1 || boe_f !== 1'b1) begin bad++; $display("FAIL t1_recover_ctrl got=%b%b exp=11", bce_f, boe_f); end
        tick;
        total++; if (rv_f !== 2'b00) begin bad++; $display("FAIL t1_resp_pulse got=%b exp=00", rv_f); end
    endtask

    task automatic test_write_ext;
        valid_f = 2'b01; addr = {32'h0, 32'h8040_0008}; be = 8'h03; wdata = {32'h0, 32'hAABB_CCDD};
        #1;
        total++; if (ready_f !== 2'b01) begin bad++; $display("FAIL t2_ready got=%b exp=01", ready_f); end
        tick; valid_f = 2'b00;
        for (int k = 0; k < 2; k++) begin
            total++; if (ea_f !== 20'h00002) begin bad++; $display("FAIL t2_addr cyc%0d got=%h exp=00002", k, ea_f); end
            total++; if (ebe_f !== 4'b1100) begin bad++; $display("FAIL t2_be_n cyc%0d got=%b exp=1100", k, ebe_f); end
            total++; if ({ece_f, eoe_f, ewe_f} !== 3'b010) begin bad++; $display("FAIL t2_ctrl cyc%0d got=%b exp=010", k, {ece_f, eoe_f, ewe_f}); end
            total++; if (ed_f !== 32'hAABB_CCDD) begin bad++; $display("FAIL t2_bus cyc%0d got=%h exp=aabbccdd", k, ed_f); end
            total++; if ({bce_f, boe_f, bwe_f} !== 3'b111) begin bad++; $display("FAIL t2_base_idle cyc%0d got=%b exp=111", k, {bce_f, boe_f, bwe_f}); end
            tick;
        end
        total++; if (rv_f !== 2'b01 || rd_f !== 32'd0) begin bad++; $display("FAIL t2_resp got=%b/%h exp=01/0", rv_f, rd_f); end
        total++; if (ewe_f !== 1'b1 || ed_f !== 32'hAABB_CCDD) begin bad++; $display("FAIL t2_hold got=%b/%h exp=1/aabbccdd", ewe_f, ed_f); end
        tick;
        total++; if (rv_f !== 2'b00) begin bad++; $display("FAIL t2_resp_pulse got=%b exp=00", rv_f); end
    endtask

    task automatic test_fixed_starve;
        logic [1:0] g [8];
        int         ng = 0;
        valid_f = 2'b11; addr = {32'h8000_0044, 32'h8000_0040}; be = 8'h00;
        for (int c = 0; c < 16; c++) begin
            #1;
            if (ready_f !== 2'b00) begin
                if (ng < 8) g[ng] = ready_f;
                ng++;
            end
            @(posedge clk);
        end
        #1; valid_f = 2'b00;
        total++; if (ng !== 4) begin bad++; $display("FAIL t3_fixed_count got=%0d exp=4", ng); end
        for (int i = 0; i < 4 && i < ng; i++) begin
            total++; if (g[i] !== 2'b01) begin bad++; $display("FAIL t3_fixed_grant%0d got=%b exp=01", i, g[i]); end
        end
        tick; tick; tick; tick;
    endtask

    task automatic test_round_robin;
        logic [1:0] g [8];
        logic [1:0] exp_g [4];
        int         ng = 0;
        exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
        reset = 1'b1; tick; reset = 1'b0;
        valid_r = 2'b11; addr = {32'h8000_0044, 32'h8000_0040}; be = 8'h00;
        for (int c = 0; c < 24; c++) begin
            #1;
            if (ready_r !== 2'b00) begin
                if (ng < 8) g[ng] = ready_r;
                ng++;
            end
            @(posedge clk);
        end
        #1; valid_r = 2'b00;
        total++; if (ng !== 4) begin bad++; $display("FAIL t3_rr_count got=%0d exp=4", ng); end
        for (int i = 0; i < 4 && i < ng; i++) begin
            total++; if (g[i] !== exp_g[i]) begin bad++; $display("FAIL t3_rr_grant%0d got=%b exp=%b", i, g[i], exp_g[i]); end
        end
        for (int c = 0; c < 7; c++) tick;
    endtask

    task automatic test_unmapped;
        valid_f = 2'b10; addr = {32'h0000_1000, 32'h0}; be = 8'h00;
        #1;
        total++; if (ready_f !== 2'b10) begin bad++; $display("FAIL t4_ready got=%b exp=10", ready_f); end
        tick; valid_f = 2'b00;
        total++; if (rv_f !== 2'b10 || rd_f !== 32'd0) begin bad++; $display("FAIL t4_resp got=%b/%h exp=10/0", rv_f, rd_f); end
        total++; if (bce_f !== 1'b1 || ece_f !== 1'b1) begin bad++; $display("FAIL t4_ce got=%b%b exp=11", bce_f, ece_f); end
        tick;
        total++; if (rv_f !== 2'b00) begin bad++; $display("FAIL t4_resp_pulse got=%b exp=00", rv_f); end
    endtask

    task automatic test_reset_abort;
        valid_f = 2'b01; addr = {32'h0, 32'h8000_0020}; be = 8'h0F; wdata = {32'h0, 32'h5566_7788};
        #1;
        total++; if (ready_f !== 2'b01) begin bad++; $display("FAIL t5_ready got=%b exp=01", ready_f); end
        tick; valid_f = 2'b00;
        tick;
        total++; if (bwe_f !== 1'b0 || bce_f !== 1'b0) begin bad++; $display("FAIL t5_second_access got=%b%b exp=00", bwe_f, bce_f); end
        reset = 1'b1;
        tick;
        total++; if ({bce_f, boe_f, bwe_f, bbe_f} !== 7'b111_1111 || ba_f !== 20'd0) begin bad++; $display("FAIL t5_abort_ctrl got=%b %h exp=1111111 0", {bce_f, boe_f, bwe_f, bbe_f}, ba_f); end
        total++; if (rv_f !== 2'b00) begin bad++; $display("FAIL t5_abort_resp got=%b exp=00", rv_f); end
        reset = 1'b0;
        tick;
        total++; if (rv_f !== 2'b00) begin bad++; $display("FAIL t5_late_resp got=%b exp=00", rv_f); end
        valid_f = 2'b01; addr = {32'h0, 32'h8000_0004}; be = 8'h00;
        #1;
        total++; if (ready_f !== 2'b01) begin bad++; $display("FAIL t5_new_ready got=%b exp=01", ready_f); end
        tick; valid_f = 2'b00;
        tick; tick;
        total++; if (rv_f !== 2'b01 || rd_f !== 32'h1234_5678) begin bad++; $display("FAIL t5_new_resp got=%b/%h exp=01/12345678", rv_f, rd_f); end
        tick;
    endtask

    task automatic test_wait3;
        valid_r = 2'b01; addr = {32'h0, 32'h8040_0000}; be = 8'h00;
        #1;
        total++; if (ready_r !== 2'b01) begin bad++; $display("FAIL t6_ready got=%b exp=01", ready_r); end
        tick; valid_r = 2'b00;
        for (int k = 0; k < 4; k++) begin
            total++; if ({ece_r, eoe_r} !== 2'b00 || rv_r !== 2'b00) begin bad++; $display("FAIL t6_access cyc%0d got=%b/%b exp=00/00", k, {ece_r, eoe_r}, rv_r); end
            tick;
        end
        total++; if (rv_r !== 2'b01 || rd_r !== 32'h9ABC_DEF0) begin bad++; $display("FAIL t6_resp got=%b/%h exp=01/9abcdef0", rv_r, rd_r); end
        total++; if (eoe_r !== 1'b1) begin bad++; $display("FAIL t6_oe_release got=%b exp=1", eoe_r); end
        tick;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset;
        test_read_base;
        test_write_ext;
        test_fixed_starve;
        test_round_robin;
        test_unmapped;
        test_reset_abort;
        test_wait3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
